// File: rtl/div_32_seq.sv
// div_32_seq: sequential unsigned 32-bit restoring divider.
// Produces one quotient bit per clock. A START pulse accepted in IDLE kicks
// off 32 iterations in RUN, then a single FIN cycle pulses DONE with Q/R valid.
// A zero divisor skips RUN entirely and reports DIV0 with Q=all-ones, R=A.
module div_32_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Q,
    output logic [31:0] R,
    output logic        BUSY,
    output logic        DONE,
    output logic        DIV0
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    // The partial remainder is always below the divisor after a restoring
    // step, so its 33rd bit is zero and only the low 32 bits are stored.
    logic [31:0] qreg;
    logic [31:0] rem;
    logic [31:0] divisor;
    logic [5:0]  count;
    logic        div0_r;
    logic        busy_r;
    logic        done_r;

    logic [32:0] rem_shift;
    logic [32:0] trial;

    // Shift in the next dividend bit and try subtracting the divisor.
    always_comb begin
        rem_shift = {rem, qreg[31]};
        trial     = rem_shift - {1'b0, divisor};
    end

    // Next-state logic: IDLE waits for START, RUN counts 32 steps, FIN lasts one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (START) begin
                    next_state = (B == 32'd0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (count == 6'd31) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Status flags are registered from the next state so BUSY/DONE come straight off flops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state == RUN);
            done_r <= (next_state == FIN);
        end
    end

    // Datapath: operand capture on accepted START, one restoring step per RUN cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            qreg    <= 32'd0;
            rem     <= 32'd0;
            divisor <= 32'd0;
            count   <= 6'd0;
            div0_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        count <= 6'd0;
                        if (B == 32'd0) begin
                            qreg   <= 32'hFFFF_FFFF;
                            rem    <= A;
                            div0_r <= 1'b1;
                        end else begin
                            qreg    <= A;
                            divisor <= B;
                            rem     <= 32'd0;
                            div0_r  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (!trial[32]) begin
                        rem  <= trial[31:0];
                        qreg <= {qreg[30:0], 1'b1};
                    end else begin
                        rem  <= rem_shift[31:0];
                        qreg <= {qreg[30:0], 1'b0};
                    end
                    count <= count + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign Q    = qreg;
    assign R    = rem;
    assign BUSY = busy_r;
    assign DONE = done_r;
    assign DIV0 = div0_r;

endmodule

// File: tb/tb_div_32_seq.sv
// tb_div_32_seq: scoreboard bench for div_32_seq with directed and random operations.
module tb_div_32_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] Q;
    logic [31:0] R;
    logic        BUSY;
    logic        DONE;
    logic        DIV0;

    div_32_seq dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .DIV0  (DIV0)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        div0;
        int          accept_cyc;
        int          delta;
        int          busy_cycles;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t last_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    // Count rising edges so the monitor can measure accept-to-DONE distance.
    always @(posedge CLK) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference result from plain integer division.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.div0 = 1'b1;
            e.delta = 0;
            e.busy_cycles = 0;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.div0 = 1'b0;
            e.delta = 32;
            e.busy_cycles = 32;
        end
        e.accept_cyc = 0;
        return e;
    endfunction

    // Monitor: tally BUSY cycles and compare each DONE against the scoreboard head.
    always @(negedge CLK) begin
        if (!RST) begin
            busy_cnt = 0;
        end else begin
            if (BUSY) busy_cnt++;
            if (DONE) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done actual=DONE required=no DONE (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("quotient", Q, mon_e.q);
                    check_output("remainder", R, mon_e.r);
                    check_output("div0", {31'd0, DIV0}, {31'd0, mon_e.div0});
                    check_output("latency", 32'(cyc - mon_e.accept_cyc), 32'(mon_e.delta));
                    check_output("busy_cycles", 32'(busy_cnt), 32'(mon_e.busy_cycles));
                end
                busy_cnt = 0;
            end
        end
    end

    // Issue one operation; called and returning on a falling edge.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input bit toggle, input bit hold);
        exp_t e;
        bit   done_seen;
        START = 1'b1;
        A = a;
        B = b;
        @(negedge CLK);
        e = model(a, b);
        e.accept_cyc = cyc;
        sb.push_back(e);
        last_e = e;
        if (toggle) begin
            A = 32'd9;
            B = 32'd2;
        end else begin
            START = 1'b0;
            A = $urandom;
            B = $urandom;
        end
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            if (i > 0) @(negedge CLK);
            if (DONE) begin
                done_seen = 1'b1;
            end else if (toggle && i > 0) begin
                A = $urandom;
                B = $urandom;
            end
        end
        if (!done_seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=no DONE required=DONE (a=%h b=%h)", a, b);
            sb.delete();
        end
        @(negedge CLK);
        START = 1'b0;
        if (hold) begin
            repeat (3) @(negedge CLK);
            check_output("hold_q", Q, last_e.q);
            check_output("hold_r", R, last_e.r);
            check_output("hold_div0", {31'd0, DIV0}, {31'd0, last_e.div0});
            check_output("hold_idle_busy", {31'd0, BUSY}, 32'd0);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, mid-run reset, then random traffic.
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        exp_t        ab;
        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        check_output("reset_q", Q, 32'd0);
        check_output("reset_r", R, 32'd0);
        check_output("reset_busy", {31'd0, BUSY}, 32'd0);
        check_output("reset_done", {31'd0, DONE}, 32'd0);
        check_output("reset_div0", {31'd0, DIV0}, 32'd0);
        RST = 1'b1;

        apply_stimulus(32'd100, 32'd7, 1'b0, 1'b1);
        apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        apply_stimulus(32'd3, 32'd10, 1'b0, 1'b0);
        apply_stimulus(32'd0, 32'd5, 1'b0, 1'b1);
        apply_stimulus(32'd5, 32'd0, 1'b0, 1'b1);
        apply_stimulus(32'd1000, 32'd3, 1'b1, 1'b0);

        // Abort an operation partway through RUN with an asynchronous reset.
        START = 1'b1;
        A = 32'd12345;
        B = 32'd17;
        @(negedge CLK);
        ab = model(32'd12345, 32'd17);
        ab.accept_cyc = cyc;
        sb.push_back(ab);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        check_output("abort_q", Q, 32'd0);
        check_output("abort_r", R, 32'd0);
        check_output("abort_busy", {31'd0, BUSY}, 32'd0);
        check_output("abort_done", {31'd0, DONE}, 32'd0);
        check_output("abort_div0", {31'd0, DIV0}, 32'd0);
        sb.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        apply_stimulus(32'd81, 32'd9, 1'b0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 16));
                2:       rb = $urandom;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 5) == 0) ra = rb;
            apply_stimulus(ra, rb, bit'(i % 7 == 3), bit'(i % 4 == 0));
        end

        repeat (40) @(negedge CLK);
        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
